operand_sign_cond: RTL and testbench

Two-stage pipelined operand conditioner for the multiplier datapath. Accepts a pair of operands under a valid/ready handshake and converts each from two's complement to sign-magnitude. Per-transaction signed/unsigned mode, product-sign generation with zero suppression, and most-negative-value flags. Sits between the operand source and the unsigned multiplier core. Its outputs feed the core directly, and its product sign drives the final re-complement stage.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/sign_mag_core.sv | 22 ++
 rtl/operand_sign_cond.sv | 130 +++++++++++++
 tb/tb_operand_sign_cond.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the multiplier operand path.
package mult_pkg;

    localparam int DW_DEFAULT = 32;

    // Default-width view of one conditioned operand; modules declare the same
    // shape at their own DW.
    typedef struct packed {
        logic [DW_DEFAULT-1:0] mag;
        logic                  sign;
        logic                  is_min;
    } sm_operand_t;

    // A zero product is always positive, whatever the operand signs.
    function automatic logic prod_sign(input logic sign_a, input logic sign_b,
                                       input logic nz_a,   input logic nz_b);
        return (sign_a ^ sign_b) & nz_a & nz_b;
    endfunction

endpackage

// File: rtl/sign_mag_core.sv
// Combinational two's-complement to sign-magnitude conversion of one operand.
module sign_mag_core #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] x_i,
    input  logic          signed_i,
    output logic [DW-1:0] mag_o,
    output logic          sign_o,
    output logic          is_min_o
);

    localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1};

    // The most-negative value negates to itself, which is the right unsigned magnitude.
    always_comb begin
        sign_o   = signed_i & x_i[DW-1];
        mag_o    = sign_o ? (~x_i + ONE) : x_i;
        is_min_o = sign_o & (x_i == MIN_VAL);
    end

endmodule

// File: rtl/operand_sign_cond.sv
// Two-stage operand conditioner: raw operand pair in, sign-magnitude pair out,
// with a valid/ready handshake on both sides.
module operand_sign_cond
    import mult_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_Valid,
    output logic          o_Ready,
    input  logic [DW-1:0] i_A,
    input  logic [DW-1:0] i_B,
    input  logic          i_Signed,
    output logic          o_Valid,
    input  logic          i_Ready,
    output logic [DW-1:0] o_MagA,
    output logic [DW-1:0] o_MagB,
    output logic          o_SignA,
    output logic          o_SignB,
    output logic          o_Signo,
    output logic          o_MinA,
    output logic          o_MinB
);

    typedef struct packed {
        logic [DW-1:0] mag;
        logic          sign;
        logic          is_min;
    } op_t;

    // Stage 1: raw operands as accepted
    logic          v1_q, v1_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic          sgn_q, sgn_d;

    // Stage 2: conditioned operands presented downstream
    logic          v2_q, v2_d;
    op_t           opa_q, opa_d;
    op_t           opb_q, opb_d;
    logic          signo_q, signo_d;

    logic          s1_load, s2_load, accept;
    logic [DW-1:0] mag_a_c, mag_b_c;
    logic          sign_a_c, sign_b_c, min_a_c, min_b_c;

    assign s2_load = !v2_q || i_Ready;
    assign s1_load = !v1_q || s2_load;
    assign accept  = i_Valid && s1_load;
    assign o_Ready = s1_load;

    sign_mag_core #(.DW(DW)) u_core_a (
        .x_i      (a_q),
        .signed_i (sgn_q),
        .mag_o    (mag_a_c),
        .sign_o   (sign_a_c),
        .is_min_o (min_a_c)
    );

    sign_mag_core #(.DW(DW)) u_core_b (
        .x_i      (b_q),
        .signed_i (sgn_q),
        .mag_o    (mag_b_c),
        .sign_o   (sign_b_c),
        .is_min_o (min_b_c)
    );

    always_comb begin
        v1_d    = v1_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        v2_d    = v2_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        signo_d = signo_q;

        if (s1_load) begin
            v1_d = i_Valid;
        end
        if (accept) begin
            a_d   = i_A;
            b_d   = i_B;
            sgn_d = i_Signed;
        end

        // Bubbles move forward without disturbing the last delivered data.
        if (s2_load) begin
            v2_d = v1_q;
            if (v1_q) begin
                opa_d   = '{mag: mag_a_c, sign: sign_a_c, is_min: min_a_c};
                opb_d   = '{mag: mag_b_c, sign: sign_b_c, is_min: min_b_c};
                signo_d = prod_sign(sign_a_c, sign_b_c, |mag_a_c, |mag_b_c);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v1_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            v2_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            signo_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            v2_q    <= v2_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            signo_q <= signo_d;
        end
    end

    assign o_Valid = v2_q;
    assign o_MagA  = opa_q.mag;
    assign o_MagB  = opb_q.mag;
    assign o_SignA = opa_q.sign;
    assign o_SignB = opb_q.sign;
    assign o_MinA  = opa_q.is_min;
    assign o_MinB  = opb_q.is_min;
    assign o_Signo = signo_q;

endmodule

// File: tb/tb_operand_sign_cond.sv
// Bench for operand_sign_cond at DW=8: directed vectors plus a random stream,
// all checked against an arithmetic reference model and a transaction queue.
module tb_operand_sign_cond;

    localparam int DW   = 8;
    localparam int HALF = 1 << (DW - 1);
    localparam int FULL = 1 << DW;

    logic          clk;
    logic          rst_n;
    logic          i_Valid, o_Ready;
    logic [DW-1:0] i_A, i_B;
    logic          i_Signed;
    logic          o_Valid, i_Ready;
    logic [DW-1:0] o_MagA, o_MagB;
    logic          o_SignA, o_SignB, o_Signo, o_MinA, o_MinB;

    operand_sign_cond #(.DW(DW)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_Valid  (i_Valid),
        .o_Ready  (o_Ready),
        .i_A      (i_A),
        .i_B      (i_B),
        .i_Signed (i_Signed),
        .o_Valid  (o_Valid),
        .i_Ready  (i_Ready),
        .o_MagA   (o_MagA),
        .o_MagB   (o_MagB),
        .o_SignA  (o_SignA),
        .o_SignB  (o_SignB),
        .o_Signo  (o_Signo),
        .o_MinA   (o_MinA),
        .o_MinB   (o_MinB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] mag_a, mag_b;
        logic          sign_a, sign_b, signo, min_a, min_b;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   armed  = 0;
    bit   zchk   = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference: interpret each operand as an integer, then take sign and |value|.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic s);
        exp_t e;
        int   va, vb;
        va = int'(a);
        vb = int'(b);
        if (s && va >= HALF) va -= FULL;
        if (s && vb >= HALF) vb -= FULL;
        e.sign_a = (va < 0);
        e.sign_b = (vb < 0);
        e.mag_a  = DW'((va < 0) ? -va : va);
        e.mag_b  = DW'((vb < 0) ? -vb : vb);
        e.min_a  = (va == -HALF);
        e.min_b  = (vb == -HALF);
        e.signo  = (e.sign_a != e.sign_b) && (va != 0) && (vb != 0);
        e.acc    = 0;
        return e;
    endfunction

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic exp_vld;
        exp_t e;
        if (zchk) begin
            check("rst_o_Valid", 32'(o_Valid), 0);
            check("rst_o_Ready", 32'(o_Ready), 1);
            check("rst_mags", {16'(o_MagA), 16'(o_MagB)}, 0);
            check("rst_flags", 32'({o_SignA, o_SignB, o_Signo, o_MinA, o_MinB}), 0);
            zchk = 0;
        end
        if (armed) begin
            exp_vld = (q.size() > 0) && (cyc >= q[0].acc + 2);
            check("o_Valid", 32'(o_Valid), 32'(exp_vld));
            check("o_Ready", 32'(o_Ready), 32'((q.size() < 2) || i_Ready));
            if (exp_vld && o_Valid) begin
                e = q[0];
                check("o_MagA", 32'(o_MagA), 32'(e.mag_a));
                check("o_MagB", 32'(o_MagB), 32'(e.mag_b));
                check("signs", 32'({o_SignA, o_SignB, o_Signo}),
                      32'({e.sign_a, e.sign_b, e.signo}));
                check("mins", 32'({o_MinA, o_MinB}), 32'({e.min_a, e.min_b}));
            end
            if (o_Valid && i_Ready && q.size() > 0) void'(q.pop_front());
            if (i_Valid && o_Ready && rst_n) begin
                e     = model(i_A, i_B, i_Signed);
                e.acc = cyc;
                q.push_back(e);
            end
        end
        if (!rst_n) begin
            q.delete();
            armed = 1;
            zchk  = 1;
        end
        cyc++;
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
        bit ok;
        ok       = 0;
        i_Valid  = 1'b1;
        i_A      = a;
        i_B      = b;
        i_Signed = s;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = o_Ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("send_timeout", 0, 1);
        i_Valid = 1'b0;
    endtask

    task automatic lit_out(input string nm, input logic [DW-1:0] ma, input logic [DW-1:0] mb,
                           input logic sa, input logic sb, input logic so,
                           input logic mna, input logic mnb);
        check({nm, "_vld"}, 32'(o_Valid), 1);
        check({nm, "_magA"}, 32'(o_MagA), 32'(ma));
        check({nm, "_magB"}, 32'(o_MagB), 32'(mb));
        check({nm, "_flags"}, 32'({o_SignA, o_SignB, o_Signo, o_MinA, o_MinB}),
              32'({sa, sb, so, mna, mnb}));
    endtask

    initial begin
        exp_t m;
        int   acc_cnt;
        rst_n    = 1'b0;
        i_Valid  = 1'b0;
        i_A      = '0;
        i_B      = '0;
        i_Signed = 1'b0;
        i_Ready  = 1'b1;

        // Pin the model with hand-computed values.
        m = model(8'hFB, 8'h03, 1'b1);
        check("model_fb03", 32'({m.mag_a, m.mag_b, m.sign_a, m.sign_b, m.signo, m.min_a, m.min_b}),
              32'({8'h05, 8'h03, 5'b10100}));
        m = model(8'h80, 8'h80, 1'b1);
        check("model_8080", 32'({m.mag_a, m.mag_b, m.sign_a, m.sign_b, m.signo, m.min_a, m.min_b}),
              32'({8'h80, 8'h80, 5'b11011}));
        m = model(8'h00, 8'hFF, 1'b0);
        check("model_00ff_u", 32'({m.mag_a, m.mag_b, m.sign_a, m.sign_b, m.signo, m.min_a, m.min_b}),
              32'({8'h00, 8'hFF, 5'b00000}));

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed pairs with literal expectations, two cycles after accept.
        send(8'hFB, 8'h03, 1'b1);
        @(posedge clk); #1;
        lit_out("basic", 8'h05, 8'h03, 1, 0, 1, 0, 0);
        send(8'h80, 8'h80, 1'b1);
        @(posedge clk); #1;
        lit_out("minneg", 8'h80, 8'h80, 1, 1, 0, 1, 1);
        send(8'h00, 8'hFF, 1'b1);
        @(posedge clk); #1;
        lit_out("zero_s", 8'h00, 8'h01, 0, 1, 0, 0, 0);
        send(8'h00, 8'hFF, 1'b0);
        @(posedge clk); #1;
        lit_out("zero_u", 8'h00, 8'hFF, 0, 0, 0, 0, 0);
        send(8'h81, 8'h7F, 1'b1);
        @(posedge clk); #1;
        lit_out("edge", 8'h7F, 8'h7F, 1, 0, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: only two pairs fit while downstream is stalled.
        i_Ready = 1'b0;
        fork
            begin
                send(8'h01, 8'hFE, 1'b1);
                send(8'hF0, 8'h10, 1'b1);
                send(8'h33, 8'hCC, 1'b0);
                send(8'h9C, 8'h80, 1'b1);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check("bp_ready_low", 32'(o_Ready), 0);
                lit_out("bp_hold", 8'h01, 8'h02, 0, 1, 1, 0, 0);
                i_Ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("bp_drained", 32'(q.size()), 0);

        // Reset while two pairs are held.
        i_Ready = 1'b0;
        send(8'h11, 8'h22, 1'b1);
        send(8'hEE, 8'hDD, 1'b1);
        @(posedge clk); #1;
        check("pre_rst_full", 32'(o_Ready), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst_valid", 32'(o_Valid), 0);
        check("post_rst_ready", 32'(o_Ready), 1);
        i_Ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_no_stale", 32'(o_Valid), 0);

        // Random stream with random downstream readiness.
        acc_cnt = 0;
        for (int k = 0; k < 20000 && acc_cnt < 1000; k++) begin
            i_Valid  = ($urandom_range(0, 3) != 0);
            i_A      = DW'($urandom);
            i_B      = DW'($urandom);
            i_Signed = $urandom_range(0, 1) != 0;
            i_Ready  = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (i_Valid && o_Ready) acc_cnt++;
            @(posedge clk);
            #1;
        end
        check("rand_accepts", 32'(acc_cnt), 1000);
        i_Valid = 1'b0;
        i_Ready = 1'b1;
        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("rand_drained", 32'(q.size()), 0);
        repeat (2) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
